// File: rtl/slot_bus_ctrl.sv
// Apple II peripheral-slot bus controller: registered device/IO selects, $C800-$CFFF
// expansion-ROM owner latch, card read-data mux and per-slot wait states with timeout.

module slot_bus_lane #(
    parameter int SLOT   = 0,
    parameter bit CFG_EN = 1'b0
) (
    input  logic        ext,
    input  logic [11:0] addr_hi,   // addr[15:4]
    input  logic        cxrom,
    input  logic [2:0]  owner,
    output logic        dev_hit,
    output logic        io_hit,
    output logic        strb_hit
);
    localparam logic [2:0] N = 3'(SLOT);

    logic valid;
    assign valid    = CFG_EN & ext;
    assign dev_hit  = valid & (addr_hi[11:3] == 9'b1100_0000_1) & (addr_hi[2:0] == N);
    assign io_hit   = valid & ~cxrom & (addr_hi[11:7] == 5'b11000) & (addr_hi[6:4] == N);
    // Strobe follows the latched owner, not the current slot enables.
    assign strb_hit = ~cxrom & (N != 3'd0) & (addr_hi[11:7] == 5'b11001) & (owner == N);
endmodule

module slot_bus_ctrl #(
    parameter int         NUM_SLOTS    = 7,
    parameter logic [7:0] SLOT_MASK    = 8'hFE,
    parameter int         WAIT_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        fast_clk,
    input  logic [7:0]  bank,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  sltromsel,
    input  logic        cxrom,
    input  logic        inhibit_cxxx,
    input  logic [63:0] slot_dout,
    input  logic [7:0]  slot_wait,
    output logic [7:0]  device_select,
    output logic [7:0]  io_select,
    output logic [7:0]  io_strobe,
    output logic [2:0]  c8_owner,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        bus_wait,
    output logic        wait_timeout
);
    localparam logic [15:0] CNT_LAST = 16'(WAIT_TIMEOUT - 1);

    logic        bank_ok, qual, we_r, expired;
    logic [7:0]  dev_hit, io_hit, strb_hit, sel;
    logic [2:0]  owner_nxt;
    logic [15:0] wait_cnt;

    assign bank_ok = (bank == 8'h00) || (bank == 8'h01) || (bank == 8'hE0) || (bank == 8'hE1);
    assign qual    = fast_clk & ~bus_wait & bank_ok & ~inhibit_cxxx;

    generate
        for (genvar n = 0; n < 8; n++) begin : g_slot
            localparam bit CFG_EN = (n >= 1) && (n <= NUM_SLOTS) && SLOT_MASK[n];
            slot_bus_lane #(.SLOT(n), .CFG_EN(CFG_EN)) u_lane (
                .ext      (sltromsel[n]),
                .addr_hi  (addr[15:4]),
                .cxrom    (cxrom),
                .owner    (c8_owner),
                .dev_hit  (dev_hit[n]),
                .io_hit   (io_hit[n]),
                .strb_hit (strb_hit[n])
            );
        end
    endgenerate

    assign sel      = device_select | io_select | io_strobe;
    assign bus_wait = |(sel & slot_wait) & ~expired;
    assign rd_hit   = |sel & ~we_r;

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < 8; i++)
            if (sel[i]) rd_data = slot_dout[8*i +: 8];
    end

    // $CFFF releases ownership; it cannot coincide with an io_select hit.
    always_comb begin
        owner_nxt = c8_owner;
        if (addr == 16'hCFFF) owner_nxt = 3'd0;
        for (int i = 1; i < 8; i++)
            if (io_hit[i]) owner_nxt = 3'(i);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            device_select <= '0;
            io_select     <= '0;
            io_strobe     <= '0;
            c8_owner      <= '0;
            we_r          <= 1'b0;
            wait_cnt      <= '0;
            expired       <= 1'b0;
            wait_timeout  <= 1'b0;
        end else if (qual) begin
            device_select <= dev_hit;
            io_select     <= io_hit;
            io_strobe     <= strb_hit;
            c8_owner      <= owner_nxt;
            we_r          <= we;
            wait_cnt      <= '0;
            expired       <= 1'b0;
        end else if (bus_wait) begin
            if (wait_cnt == CNT_LAST) begin
                expired      <= 1'b1;
                wait_timeout <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_slot_bus_ctrl.sv
// Bench for slot_bus_ctrl: directed scenarios then random traffic, two parameter sets,
// every cycle compared against a behavioural model of the slot bus rules.

module tb_slot_bus_ctrl;
    localparam int W = 4;

    logic        clk_sys = 1'b0;
    logic        reset, fast_clk, we, cxrom, inhibit_cxxx;
    logic [7:0]  bank, sltromsel, slot_wait;
    logic [15:0] addr;
    logic [63:0] slot_dout;

    logic [7:0] dsel [2];
    logic [7:0] isel [2];
    logic [7:0] istb [2];
    logic [7:0] rdd  [2];
    logic [2:0] own  [2];
    logic       hit  [2];
    logic       bw   [2];
    logic       wto  [2];

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    slot_bus_ctrl #(.NUM_SLOTS(7), .SLOT_MASK(8'hFE), .WAIT_TIMEOUT(W)) u_full (
        .clk_sys(clk_sys), .reset(reset), .fast_clk(fast_clk), .bank(bank), .addr(addr),
        .we(we), .sltromsel(sltromsel), .cxrom(cxrom), .inhibit_cxxx(inhibit_cxxx),
        .slot_dout(slot_dout), .slot_wait(slot_wait),
        .device_select(dsel[0]), .io_select(isel[0]), .io_strobe(istb[0]), .c8_owner(own[0]),
        .rd_data(rdd[0]), .rd_hit(hit[0]), .bus_wait(bw[0]), .wait_timeout(wto[0]));

    slot_bus_ctrl #(.NUM_SLOTS(7), .SLOT_MASK(8'h80), .WAIT_TIMEOUT(W)) u_mask (
        .clk_sys(clk_sys), .reset(reset), .fast_clk(fast_clk), .bank(bank), .addr(addr),
        .we(we), .sltromsel(sltromsel), .cxrom(cxrom), .inhibit_cxxx(inhibit_cxxx),
        .slot_dout(slot_dout), .slot_wait(slot_wait),
        .device_select(dsel[1]), .io_select(isel[1]), .io_strobe(istb[1]), .c8_owner(own[1]),
        .rd_data(rdd[1]), .rd_hit(hit[1]), .bus_wait(bw[1]), .wait_timeout(wto[1]));

    // Reference model state, one set per instance
    bit [7:0] mask_m [2];
    bit [7:0] m_dev [2];
    bit [7:0] m_io  [2];
    bit [7:0] m_stb [2];
    int       m_own [2];
    bit       m_we  [2];
    int       m_hi  [2];   // cycles bus_wait has been high in the current stall
    bit       m_exp [2];
    bit       m_to  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit slot_ok(int d, int n);
        return n >= 1 && n <= 7 && mask_m[d][n] && sltromsel[n];
    endfunction

    function automatic bit m_bw(int d);
        return (((m_dev[d] | m_io[d] | m_stb[d]) & slot_wait) != 0) && !m_exp[d];
    endfunction

    // Applies the bus rules for the edge about to happen, using the present inputs.
    task automatic model_edge(int d);
        int a, n;
        bit q;
        a = int'(addr);
        q = fast_clk && !m_bw(d) && !inhibit_cxxx &&
            (bank == 8'h00 || bank == 8'h01 || bank == 8'hE0 || bank == 8'hE1);
        if (reset) begin
            m_dev[d] = 0; m_io[d] = 0; m_stb[d] = 0; m_own[d] = 0;
            m_we[d] = 0; m_hi[d] = 0; m_exp[d] = 0; m_to[d] = 0;
        end else if (q) begin
            m_dev[d] = 0; m_io[d] = 0; m_stb[d] = 0;
            if (a >= 'hC080 && a <= 'hC0FF) begin
                n = (a - 'hC080) / 16;
                if (slot_ok(d, n)) m_dev[d][n] = 1'b1;
            end
            if (a >= 'hC800 && a <= 'hCFFF && !cxrom && m_own[d] != 0)
                m_stb[d][m_own[d]] = 1'b1;
            if (a >= 'hC100 && a <= 'hC7FF && !cxrom) begin
                n = (a - 'hC000) / 256;
                if (slot_ok(d, n)) begin
                    m_io[d][n] = 1'b1;
                    m_own[d] = n;
                end
            end
            if (a == 'hCFFF) m_own[d] = 0;
            m_we[d] = we; m_hi[d] = 0; m_exp[d] = 0;
        end else if (m_bw(d)) begin
            m_hi[d]++;
            if (m_hi[d] == W) begin
                m_exp[d] = 1'b1;
                m_to[d] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit [7:0] sel, rd;
        for (int d = 0; d < 2; d++) begin
            sel = m_dev[d] | m_io[d] | m_stb[d];
            rd = 8'h00;
            for (int n = 0; n < 8; n++) if (sel[n]) rd = slot_dout[8*n +: 8];
            chk($sformatf("dev%0d", d), dsel[d], m_dev[d]);
            chk($sformatf("io%0d", d), isel[d], m_io[d]);
            chk($sformatf("stb%0d", d), istb[d], m_stb[d]);
            chk($sformatf("own%0d", d), own[d], m_own[d]);
            chk($sformatf("rd%0d", d), rdd[d], rd);
            chk($sformatf("hit%0d", d), hit[d], (sel != 0) && !m_we[d]);
            chk($sformatf("bw%0d", d), bw[d], m_bw(d));
            chk($sformatf("wto%0d", d), wto[d], m_to[d]);
        end
    endtask

    task automatic cyc();
        model_edge(0);
        model_edge(1);
        @(posedge clk_sys);
        #1;
        check_all();
    endtask

    task automatic access(input logic [7:0] b, input logic [15:0] a, input logic w);
        bank = b; addr = a; we = w; fast_clk = 1'b1;
        cyc();
        fast_clk = 1'b0;
    endtask

    initial begin
        int n_hi;
        mask_m[0] = 8'hFE; mask_m[1] = 8'h80;
        reset = 1'b1; fast_clk = 1'b0; we = 1'b0; cxrom = 1'b0; inhibit_cxxx = 1'b0;
        bank = 8'h00; addr = 16'h0000; sltromsel = 8'hFE; slot_wait = 8'h00;
        slot_dout = 64'h7766554433221100;

        cyc();
        chk("rst_dev", dsel[0], 8'h00);
        chk("rst_own", own[0], 3'd0);
        chk("rst_rd", rdd[0], 8'h00);
        reset = 1'b0;
        cyc();

        access(8'h00, 16'hC0F3, 1'b0);
        chk("c0f3_dev", dsel[0], 8'h80);
        chk("c0f3_rd", rdd[0], 8'h77);
        chk("c0f3_hit", hit[0], 1'b1);
        repeat (3) cyc();
        chk("c0f3_hold", dsel[0], 8'h80);
        sltromsel = 8'h7E;
        access(8'h00, 16'hC0F3, 1'b0);
        chk("c0f3_int", dsel[0], 8'h00);
        sltromsel = 8'hFE;

        access(8'h00, 16'hC600, 1'b0);
        chk("c600_io", isel[0], 8'h40);
        chk("c600_own", own[0], 3'd6);
        access(8'h00, 16'hC900, 1'b0);
        chk("c900_stb", istb[0], 8'h40);
        access(8'h00, 16'hCFFF, 1'b0);
        chk("cfff_stb", istb[0], 8'h40);
        chk("cfff_own", own[0], 3'd0);
        access(8'h00, 16'hC900, 1'b0);
        chk("c900_nostb", istb[0], 8'h00);

        access(8'h00, 16'hC500, 1'b0);
        chk("c500_own", own[0], 3'd5);
        access(8'h00, 16'hC700, 1'b1);
        chk("c700_own", own[0], 3'd7);
        chk("c700_wr_hit", hit[0], 1'b0);
        access(8'h00, 16'hC500, 1'b0);
        cxrom = 1'b1;
        access(8'h00, 16'hC700, 1'b0);
        chk("cxrom_own", own[0], 3'd5);
        chk("cxrom_io", isel[0], 8'h00);
        cxrom = 1'b0;

        access(8'h00, 16'hC0D0, 1'b0);
        chk("mask_dev", dsel[1], 8'h00);
        chk("full_dev", dsel[0], 8'h20);
        access(8'h00, 16'h1234, 1'b0);
        access(8'h02, 16'hC0F3, 1'b0);
        chk("bank02", dsel[0], 8'h00);
        inhibit_cxxx = 1'b1;
        access(8'hE1, 16'hC0F3, 1'b0);
        chk("inhibit", dsel[0], 8'h00);
        inhibit_cxxx = 1'b0;

        slot_wait = 8'h80;
        access(8'h00, 16'hC0F3, 1'b0);
        chk("stall_start", bw[0], 1'b1);
        n_hi = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bw[0]) n_hi++;
        end
        chk("stall_len", n_hi, W);
        chk("timeout_flag", wto[0], 1'b1);
        slot_wait = 8'h00;
        access(8'h00, 16'h0400, 1'b0);
        chk("timeout_sticky", wto[0], 1'b1);

        access(8'h00, 16'hC300, 1'b0);
        chk("c300_own", own[0], 3'd3);
        slot_wait = 8'h08;
        cyc();
        chk("stall3", bw[0], 1'b1);
        reset = 1'b1;
        cyc();
        chk("rst_own3", own[0], 3'd0);
        chk("rst_bw", bw[0], 1'b0);
        chk("rst_wto", wto[0], 1'b0);
        chk("rst_io", isel[0], 8'h00);
        reset = 1'b0;
        slot_wait = 8'h00;

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: addr = 16'hC080 + 16'($urandom_range(0, 127));
                1: addr = 16'hC100 + 16'($urandom_range(0, 16'h6FF));
                2: addr = 16'hC800 + 16'($urandom_range(0, 16'h7FF));
                3: addr = 16'hCFFF;
                4: addr = 16'hC000 + 16'($urandom_range(0, 16'hFFF));
                default: addr = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: bank = 8'h00;
                1: bank = 8'h01;
                2: bank = 8'hE0;
                3: bank = 8'hE1;
                4: bank = 8'h02;
                default: bank = 8'hFF;
            endcase
            fast_clk = ($urandom_range(0, 2) == 0);
            we = 1'($urandom);
            if ($urandom_range(0, 7) == 0) sltromsel = 8'($urandom) | 8'($urandom);
            if ($urandom_range(0, 7) == 0) slot_wait = 8'($urandom) & 8'($urandom);
            cxrom = ($urandom_range(0, 7) == 0);
            inhibit_cxxx = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 149) == 0);
            slot_dout = {$urandom, $urandom};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slot_bus_ctrl.md
# slot_bus_ctrl

Parametrised Apple II peripheral-slot bus controller for the IIgs core. It replaces the single-slot-7 device/IO select logic with a generic decoder for up to seven slots. It also adds three things: registered selects, the $C800–$CFFF expansion-ROM ownership latch (I/O strobe), and per-slot wait-state handling with a timeout. It sits between the core's bank/address/data bus and the slot cards (HDD, future disk/serial/mouse cards), and supplies card read data to the top-level din mux.

## Interface
- NUM_SLOTS, 7: highest slot number implemented (1–7).
- SLOT_MASK, 8'hFE: bit n=1 enables slot n. Bit 0 is ignored. Slots above NUM_SLOTS are ignored.
- WAIT_TIMEOUT, 255: maximum clk_sys cycles a card may stall one access (1–65535).

- clk_sys  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- fast_clk  in  1  bus-cycle strobe; the decode is sampled only on cycles where it is 1.
- bank  in  8  CPU bank.
- addr  in  16  CPU address.
- we  in  1  write enable for the current bus cycle.
- sltromsel  in  8  SLTROMSEL. Bit n=1 means slot n is external.
- cxrom  in  1  internal Cx ROM forced.
- inhibit_cxxx  in  1  Cxxx space disabled.
- slot_dout  in  64  card read data, packed; slot n at [8n+7:8n].
- slot_wait  in  8  per-slot stall request.
- device_select  out  8  one-hot, registered; $C0n0–$C0nF with addr[7]=1, slot n=addr[6:4].
- io_select  out  8  one-hot, registered; $Cn00–$CnFF.
- io_strobe  out  8  one-hot, registered; $C800–$CFFF access for the current owner.
- c8_owner  out  3  current expansion-ROM owner (0 = none).
- rd_data  out  8  selected card's slot_dout.
- rd_hit  out  1  read cycle with any select/strobe active.
- bus_wait  out  1  stall request to the CPU.
- wait_timeout  out  1  sticky flag: a stall hit WAIT_TIMEOUT.

## Operation
- Qualifying cycle: fast_clk=1, bus_wait=0, bank ∈ {00,01,E0,E1}, inhibit_cxxx=0. No other cycle changes selects or owner.
- A slot n is valid when 1≤n≤NUM_SLOTS, SLOT_MASK[n]=1 and sltromsel[n]=1.
- device_select[n] is set when addr ∈ $C080–$C0FF and n=addr[6:4] is valid.
- io_select[n] is set when addr[15:11]=5'b11000, n=addr[10:8]≠0, n is valid and cxrom=0.
- Expansion-ROM owner latch, c8_owner:
  - On a qualifying cycle that sets io_select[n]: owner←n.
  - On a qualifying cycle with addr=$CFFF, read or write: owner←0, regardless of cxrom.
  - The $CFFF access still pulses io_strobe for the old owner.
- io_strobe[owner] is set on a qualifying cycle with addr ∈ $C800–$CFFF, owner≠0 and cxrom=0.
- On a qualifying cycle that matches nothing, all selects are 0.
- rd_data = slot_dout of the slot whose select or strobe is active; 8'h00 when none.
- rd_hit = (any select) & ~we_r, where we_r is we registered with the selects.
- Wait handling:
  - bus_wait = |((device_select|io_select|io_strobe) & slot_wait) & ~expired.
  - A 16-bit counter increments each clk_sys cycle while bus_wait=1.
  - When the count reaches WAIT_TIMEOUT-1: expired←1, wait_timeout←1 (sticky), bus_wait falls.
  - The counter and expired clear on the next qualifying cycle.
- wait_timeout clears only on reset.

## Timing
- Reset values: all selects 0, io_strobe 0, c8_owner 0, counter 0, expired 0, wait_timeout 0, bus_wait 0, rd_hit 0, rd_data 8'h00.
- Decode latency: decode is sampled on edge E of a fast_clk=1 cycle; selects are valid from E+1.
- Selects hold until the next qualifying cycle re-decodes them. This is one full fast_clk period when the clock is divided by 8.
- The owner update is visible at E+1, in the same cycle as io_select.
- bus_wait is combinational from the registered selects and slot_wait. It may assert in cycle E+1.
- While bus_wait=1, fast_clk pulses are ignored.
- Timeout: bus_wait deasserts exactly WAIT_TIMEOUT cycles after it first asserts, provided slot_wait stays high.
- Reset mid-stall: all state clears at the next edge and bus_wait drops.

## Test plan
- Read $00:C0F3, slot 7 external:
  - device_select=8'h80 from E+1; rd_data=slot_dout[63:56]; rd_hit=1.
  - Same access with sltromsel[7]=0 → all selects 0.
- Expansion-ROM ownership sequence:
  - Read $C600 → io_select=8'h40, c8_owner=6.
  - Read $C900 → io_strobe=8'h40.
  - Read $CFFF → io_strobe=8'h40, then c8_owner=0.
  - Read $C900 → io_strobe=0.
- Owner switching: access $C500 then $C700 → c8_owner=5, then 7. cxrom=1 on $C700 → owner stays 5, io_select=0.
- Masking and qualifiers:
  - SLOT_MASK=8'h80, NUM_SLOTS=7, access $C0D0 (slot 5) → no device_select.
  - bank $02 → no selects.
  - inhibit_cxxx=1 → no selects.
- Wait timeout: WAIT_TIMEOUT=4, slot 7 holds slot_wait=1 → bus_wait high exactly 4 cycles; wait_timeout=1 and stays 1 after the next access.
- Reset mid-stall: reset asserted during a stall with c8_owner=3 → next cycle c8_owner=0, bus_wait=0, wait_timeout=0, selects 0.
